// File: rtl/serial_alu_sequencer_if.sv
// Request/response bundle between the register-file read stage and the serial ALU sequencer.
// The sequencer takes the slave modport; whoever issues operations takes the master modport.
interface serial_alu_sequencer_if #(
   parameter int unsigned WIDTH = 64
) ();
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             negative;
   logic             zero;
   logic             overflow;
   logic             carry_out;

   modport slave (
      input  start, op, a, b,
      output busy, done, result, negative, zero, overflow, carry_out
   );

   modport master (
      output start, op, a, b,
      input  busy, done, result, negative, zero, overflow, carry_out
   );
endinterface

// File: rtl/serial_alu_sequencer.sv
// Bit-serial controller for an external 1-bit ALU slice: feeds operands LSB first over WIDTH
// cycles, threads Cout back into Cin, assembles the result and produces LEGv8 N/Z/V/C flags.
module serial_alu_sequencer #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   serial_alu_sequencer_if.slave bus,
   output logic                  slice_A,
   output logic                  slice_B,
   output logic                  slice_Cin,
   output logic [2:0]            slice_sel,
   input  logic                  slice_Cout,
   input  logic                  slice_R
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] res_q;
   logic [2:0]       op_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;
   logic             neg_q;
   logic             zero_q;
   logic             ovf_q;
   logic             cout_q;

   logic [WIDTH-1:0] res_next;
   logic             arith;
   logic             start_arith;

   assign res_next    = {slice_R, res_q[WIDTH-1:1]};
   assign arith       = (op_q[2:1] == 2'b01);
   assign start_arith = (bus.op[2:1] == 2'b01);

   // Operand shifters drain to zero and op/carry are cleared on the last step, so the slice
   // inputs read as 0 whenever the sequencer is not in RUN.
   assign slice_A   = a_sh_q[0];
   assign slice_B   = b_sh_q[0];
   assign slice_Cin = carry_q;
   assign slice_sel = op_q;

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = res_q;
   assign bus.negative  = neg_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = ovf_q;
   assign bus.carry_out = cout_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         op_q    <= 3'b000;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         neg_q   <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q <= StRun;
                  busy_q  <= 1'b1;
                  a_sh_q  <= bus.a;
                  b_sh_q  <= bus.b;
                  op_q    <= bus.op;
                  cnt_q   <= '0;
                  // Subtract needs the +1 of A + ~B + 1 injected as the initial carry.
                  carry_q <= start_arith & bus.op[0];
               end
            end
            StRun: begin
               a_sh_q  <= a_sh_q >> 1;
               b_sh_q  <= b_sh_q >> 1;
               res_q   <= res_next;
               carry_q <= slice_Cout;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LastCnt) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  neg_q   <= res_next[WIDTH-1];
                  zero_q  <= (res_next == '0);
                  // carry_q still holds the carry into the MSB slice here.
                  ovf_q   <= arith & (carry_q ^ slice_Cout);
                  cout_q  <= arith & slice_Cout;
                  op_q    <= 3'b000;
                  carry_q <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
